// File: rtl/axi_irq_ctrl_pkg.sv
// axi_irq_ctrl_pkg: register map, response codes and FSM state types for the AXI-lite interrupt controller
package axi_irq_ctrl_pkg;

    localparam logic [31:0] IRQC_RAW_OFFS_p     = 32'h000;
    localparam logic [31:0] IRQC_PENDING_OFFS_p = 32'h004;
    localparam logic [31:0] IRQC_ENABLE_OFFS_p  = 32'h008;
    localparam logic [31:0] IRQC_TRIGGER_OFFS_p = 32'h00C;
    localparam logic [31:0] IRQC_ACTIVE_OFFS_p  = 32'h010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    typedef enum logic [2:0] {
        REG_RAW,
        REG_PENDING,
        REG_ENABLE,
        REG_TRIGGER,
        REG_ACTIVE,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        return (addr == IRQC_RAW_OFFS_p)     ? REG_RAW     :
               (addr == IRQC_PENDING_OFFS_p) ? REG_PENDING :
               (addr == IRQC_ENABLE_OFFS_p)  ? REG_ENABLE  :
               (addr == IRQC_TRIGGER_OFFS_p) ? REG_TRIGGER :
               (addr == IRQC_ACTIVE_OFFS_p)  ? REG_ACTIVE  : REG_NONE;
    endfunction

endpackage

// File: rtl/axi_irq_ctrl.sv
// axi_irq_ctrl: AXI4-lite interrupt controller with level/edge pending bits, enable mask and a registered CPU irq
module axi_irq_ctrl
    import axi_irq_ctrl_pkg::*;
#(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    input  logic [31:0]              i_axi_wdata,
    input  logic                     i_axi_wvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    input  logic                     i_axi_rready,
    output logic                     o_axi_awready,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    output logic                     o_irq
);

    // Registers are kept 32 bits wide; bits above IRQ_NBR_p are forced to 0 by this mask
    localparam logic [31:0] IRQ_MASK_p = 32'((33'd1 << IRQ_NBR_p) - 33'd1);

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    reg_sel_e    wsel, rsel;
    logic        wr_hs, rd_hs, irq_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, rd_mux;
    logic [31:0] src_w, src_q, rise, w1c;
    logic [31:0] pending_q, pending_d, enable_q, trigger_q, active;

    assign wsel   = decode_addr(32'(i_axi_awaddr));
    assign rsel   = decode_addr(32'(i_axi_araddr));
    assign src_w  = 32'(i_irq_src);
    assign active = pending_q & enable_q;
    assign rise   = src_w & ~src_q;
    assign w1c    = (wr_hs && wsel == REG_PENDING) ? (i_axi_wdata & IRQ_MASK_p) : '0;

    // Edge bits: a new rising edge beats a simultaneous W1C. Level bits simply follow the source.
    assign pending_d = (trigger_q & ((pending_q & ~w1c) | rise)) | (~trigger_q & src_w);

    always_comb begin
        rd_mux = (rsel == REG_RAW)     ? src_w     :
                 (rsel == REG_PENDING) ? pending_q :
                 (rsel == REG_ENABLE)  ? enable_q  :
                 (rsel == REG_TRIGGER) ? trigger_q :
                 (rsel == REG_ACTIVE)  ? active    : '0;
    end

    always_comb begin
        wr_hs      = (wr_state_q == WR_IDLE) && i_axi_awvalid && i_axi_wvalid;
        wr_state_d = wr_hs ? WR_RESP :
                     (wr_state_q == WR_RESP && i_axi_bready) ? WR_IDLE : wr_state_q;
    end

    always_comb begin
        rd_hs      = (rd_state_q == RD_IDLE) && i_axi_arvalid;
        rd_state_d = rd_hs ? RD_DATA :
                     (rd_state_q == RD_DATA && i_axi_rready) ? RD_IDLE : rd_state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    // src_q only tracks edge-mode sources, so a source already high becomes an edge once TRIGGER is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            trigger_q <= '0;
            irq_q     <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            src_q     <= src_w & trigger_q;
            pending_q <= pending_d;
            irq_q     <= |active;
            if (wr_hs && wsel == REG_ENABLE)
                enable_q <= i_axi_wdata & IRQ_MASK_p;
            if (wr_hs && wsel == REG_TRIGGER)
                trigger_q <= i_axi_wdata & IRQ_MASK_p;
            if (wr_hs)
                bresp_q <= (wsel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            if (rd_hs) begin
                rdata_q <= rd_mux;
                rresp_q <= (rsel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign o_axi_awready = wr_hs;
    assign o_axi_wready  = wr_hs;
    assign o_axi_bvalid  = (wr_state_q == WR_RESP);
    assign o_axi_bresp   = bresp_q;
    assign o_axi_arready = rd_hs;
    assign o_axi_rvalid  = (rd_state_q == RD_DATA);
    assign o_axi_rdata   = rdata_q;
    assign o_axi_rresp   = rresp_q;
    assign o_irq         = irq_q;

endmodule
